// File: rtl/lsf_hit_framer.sv
// Frames one HEG SLC and its hit stream for the LSF spy-buffer wrapper: ROI word first, then up to
// MAX_HITS windowed hits through a local FIFO, under downstream almost-full back-pressure.
module lsf_hit_framer #(
  parameter int unsigned SLC_W         = 64,
  parameter int unsigned HIT_W         = 40,
  parameter int unsigned WINDOW_CYCLES = 64,
  parameter int unsigned MAX_HITS      = 32,
  parameter int unsigned FIFO_DEPTH    = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [SLC_W-1:0] slc_in,
  input  logic             slc_in_vld,
  output logic             slc_rdy,
  input  logic [HIT_W-1:0] hit_in,
  input  logic             hit_in_vld,
  input  logic             roi_af,
  input  logic             hit_af,
  output logic [SLC_W-1:0] roi,
  output logic             roi_we,
  output logic [HIT_W-1:0] mdt_hit,
  output logic             mdt_hit_we,
  output logic             frame_done,
  output logic [7:0]       frame_hits,
  output logic [15:0]      drop_cnt
);

  localparam int unsigned WIN_W = $clog2(WINDOW_CYCLES + 1);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] SEND_ROI = 2'd1;
  localparam logic [1:0] FWD_HITS = 2'd2;
  localparam logic [1:0] CLOSE    = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [SLC_W-1:0] slc_q;
  logic [WIN_W-1:0] win_cnt_q;
  logic [7:0]       hit_cnt_q;
  logic [PTR_W:0]   wr_ptr_q, rd_ptr_q;
  logic [HIT_W-1:0] mem [FIFO_DEPTH];

  logic [SLC_W-1:0] roi_q;
  logic             roi_we_q;
  logic [HIT_W-1:0] mdt_hit_q;
  logic             mdt_hit_we_q;
  logic             frame_done_q;
  logic [7:0]       frame_hits_q;
  logic [15:0]      drop_cnt_q;

  logic fifo_empty, fifo_full;
  logic slc_accept, in_window, hit_push, hit_drop, hit_pop, roi_send;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

  assign slc_accept = (state_q == IDLE) && slc_in_vld;
  assign in_window  = ((state_q == SEND_ROI) || (state_q == FWD_HITS)) && (win_cnt_q != '0);
  // Full is judged on the pre-pop occupancy, so a pop never frees room for a same-cycle push.
  assign hit_push   = hit_in_vld && in_window && (hit_cnt_q < 8'(MAX_HITS)) && !fifo_full;
  assign hit_drop   = hit_in_vld && !hit_push;
  // Popping only in FWD_HITS keeps every hit behind its frame's ROI word.
  assign hit_pop    = (state_q == FWD_HITS) && !fifo_empty && !hit_af;
  assign roi_send   = (state_q == SEND_ROI) && !roi_af;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (slc_in_vld) state_d = SEND_ROI;
      SEND_ROI: if (!roi_af) state_d = FWD_HITS;
      FWD_HITS: if ((win_cnt_q == '0) && fifo_empty && !mdt_hit_we_q) state_d = CLOSE;
      CLOSE:    state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      slc_q        <= '0;
      win_cnt_q    <= '0;
      hit_cnt_q    <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      roi_q        <= '0;
      roi_we_q     <= 1'b0;
      mdt_hit_q    <= '0;
      mdt_hit_we_q <= 1'b0;
      frame_done_q <= 1'b0;
      frame_hits_q <= '0;
      drop_cnt_q   <= '0;
    end else begin
      state_q <= state_d;

      if (slc_accept) begin
        slc_q     <= slc_in;
        win_cnt_q <= WIN_W'(WINDOW_CYCLES);
        hit_cnt_q <= '0;
      end else begin
        if (in_window) win_cnt_q <= win_cnt_q - WIN_W'(1);
        if (hit_push)  hit_cnt_q <= hit_cnt_q + 8'd1;
      end

      if (hit_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (hit_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;

      roi_we_q <= roi_send;
      if (roi_send) roi_q <= slc_q;

      mdt_hit_we_q <= hit_pop;
      if (hit_pop) mdt_hit_q <= mem[rd_ptr_q[PTR_W-1:0]];

      frame_done_q <= (state_q == FWD_HITS) && (state_d == CLOSE);
      if ((state_q == FWD_HITS) && (state_d == CLOSE)) frame_hits_q <= hit_cnt_q;

      if (hit_drop && (drop_cnt_q != 16'hFFFF)) drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (hit_push) mem[wr_ptr_q[PTR_W-1:0]] <= hit_in;
  end

  assign slc_rdy    = (state_q == IDLE);
  assign roi        = roi_q;
  assign roi_we     = roi_we_q;
  assign mdt_hit    = mdt_hit_q;
  assign mdt_hit_we = mdt_hit_we_q;
  assign frame_done = frame_done_q;
  assign frame_hits = frame_hits_q;
  assign drop_cnt   = drop_cnt_q;

endmodule
